// File: rtl/muxn_pkg.sv
// Shared definitions for the muxn_reg slice: selection-mode constants and the
// select-width helper used to size channel indices.
package muxn_pkg;

   localparam int MUXN_FIXED = 0;
   localparam int MUXN_RR    = 1;

   // Width of a channel index; never narrower than one bit.
   function automatic int selWidth(input int n);
      return (n < 2) ? 1 : $clog2(n);
   endfunction

endpackage

// File: rtl/muxn_rr_arb.sv
// Round-robin arbiter for muxn_reg: picks the first requesting channel at or
// after the rotating pointer, and moves the pointer past the grant on advance.
module muxn_rr_arb
   import muxn_pkg::*;
#(
   parameter int N = 4
) (
   input  logic                   i_clk,
   input  logic                   i_rst,
   input  logic [N-1:0]           i_req,
   input  logic                   i_advance,
   output logic [selWidth(N)-1:0] o_grant,
   output logic                   o_grantValid
);

   localparam int SW = selWidth(N);

   logic [SW-1:0] r_ptr;

   // Wrapped candidates (below the pointer) are scanned first so that any
   // candidate at or above the pointer overrides them; the lowest index wins.
   always_comb begin
      o_grant      = '0;
      o_grantValid = 1'b0;
      for (int c = N - 1; c >= 0; c--) begin
         if (i_req[c] && (SW'(c) < r_ptr)) begin
            o_grant      = SW'(c);
            o_grantValid = 1'b1;
         end
      end
      for (int c = N - 1; c >= 0; c--) begin
         if (i_req[c] && (SW'(c) >= r_ptr)) begin
            o_grant      = SW'(c);
            o_grantValid = 1'b1;
         end
      end
   end

   always_ff @(posedge i_clk) begin
      if (i_rst) begin
         r_ptr <= '0;
      end else if (i_advance && o_grantValid) begin
         r_ptr <= (int'(o_grant) == N - 1) ? '0 : o_grant + 1'b1;
      end
   end

endmodule

// File: rtl/muxn_reg.sv
// N-to-1 registered multiplexer with valid/ready handshakes, fixed or round-robin
// channel selection; define MUXN_REG_PARITY_EN to add the registered OUT_PAR bit.
module muxn_reg
   import muxn_pkg::*;
#(
   parameter int N    = 4,
   parameter int W    = 8,
   parameter int MODE = MUXN_FIXED
) (
   input  logic                   CLK,
   input  logic                   RST,
   input  logic [N*W-1:0]         IN_DATA,
   input  logic [N-1:0]           IN_VALID,
   output logic [N-1:0]           IN_READY,
   input  logic [selWidth(N)-1:0] SEL,
   input  logic                   SEL_LOAD,
   output logic                   SEL_ERR,
   output logic [W-1:0]           OUT_DATA,
   output logic [selWidth(N)-1:0] OUT_CH,
   output logic                   OUT_VALID,
   input  logic                   OUT_READY
`ifdef MUXN_REG_PARITY_EN
   ,
   output logic                   OUT_PAR
`endif
);

   localparam int SW = selWidth(N);

   logic [SW-1:0] r_selQ;
   logic          r_selErr;
   logic [W-1:0]  r_outData;
   logic [SW-1:0] r_outCh;
   logic          r_outValid;

   logic          w_slotFree;
   logic          w_xfer;
   logic          w_haveChosen;
   logic [SW-1:0] w_chosen;
   logic [W-1:0]  w_chosenData;
   logic          w_chosenValid;
   logic [N-1:0]  w_inReady;

   assign w_slotFree = !r_outValid || OUT_READY;

   generate
      if (MODE == MUXN_RR) begin : g_rr
         logic [SW-1:0] w_rrGrant;
         logic          w_rrValid;

         muxn_rr_arb #(
            .N(N)
         ) u_arb (
            .i_clk       (CLK),
            .i_rst       (RST),
            .i_req       (IN_VALID),
            .i_advance   (w_xfer),
            .o_grant     (w_rrGrant),
            .o_grantValid(w_rrValid)
         );

         assign w_chosen     = w_rrGrant;
         assign w_haveChosen = w_rrValid;
      end else begin : g_fixed
         assign w_chosen     = r_selQ;
         assign w_haveChosen = 1'b1;
      end
   endgenerate

   // Route the chosen channel; ready is offered only to it, never during reset.
   always_comb begin
      w_chosenData  = '0;
      w_chosenValid = 1'b0;
      w_inReady     = '0;
      for (int c = 0; c < N; c++) begin
         if (w_haveChosen && (w_chosen == SW'(c))) begin
            w_chosenData  = IN_DATA[c*W +: W];
            w_chosenValid = IN_VALID[c];
            w_inReady[c]  = w_slotFree && !RST;
         end
      end
   end

   assign w_xfer = w_haveChosen && w_chosenValid && w_slotFree && !RST;

   always_ff @(posedge CLK) begin
      if (RST) begin
         r_outValid <= 1'b0;
         r_outData  <= '0;
         r_outCh    <= '0;
      end else if (w_xfer) begin
         r_outValid <= 1'b1;
         r_outData  <= w_chosenData;
         r_outCh    <= w_chosen;
      end else if (OUT_READY) begin
         r_outValid <= 1'b0;
      end
   end

   // Out-of-range loads are rejected and flagged for exactly one cycle.
   always_ff @(posedge CLK) begin
      if (RST) begin
         r_selQ   <= '0;
         r_selErr <= 1'b0;
      end else begin
         r_selErr <= 1'b0;
         if ((MODE == MUXN_FIXED) && SEL_LOAD) begin
            if (int'(SEL) < N) begin
               r_selQ <= SEL;
            end else begin
               r_selErr <= 1'b1;
            end
         end
      end
   end

`ifdef MUXN_REG_PARITY_EN
   logic r_outPar;

   always_ff @(posedge CLK) begin
      if (RST) begin
         r_outPar <= 1'b0;
      end else if (w_xfer) begin
         r_outPar <= ^w_chosenData;
      end
   end

   assign OUT_PAR = r_outPar;
`endif

   assign IN_READY  = w_inReady;
   assign SEL_ERR   = r_selErr;
   assign OUT_DATA  = r_outData;
   assign OUT_CH    = r_outCh;
   assign OUT_VALID = r_outValid;

endmodule

// File: tb/tb_muxn_reg.sv
// Self-checking bench for muxn_reg: fixed-select instance driven from a vector
// table, plus hand-written sequences for select errors and round-robin.
module tb_muxn_reg;

   logic clk;
   int   checks;
   int   errors;

   // Fixed-select instance, N=4 W=8.
   logic        rst0;
   logic [31:0] inData0;
   logic [3:0]  inValid0;
   logic [3:0]  inReady0;
   logic [1:0]  sel0;
   logic        selLoad0;
   logic        selErr0;
   logic [7:0]  outData0;
   logic [1:0]  outCh0;
   logic        outValid0;
   logic        outReady0;

   // Fixed-select instance, N=5, so a 3-bit SEL can name a missing channel.
   logic        rstE;
   logic [39:0] inDataE;
   logic [4:0]  inValidE;
   logic [4:0]  inReadyE;
   logic [2:0]  selE;
   logic        selLoadE;
   logic        selErrE;
   logic [7:0]  outDataE;
   logic [2:0]  outChE;
   logic        outValidE;
   logic        outReadyE;

   // Round-robin instance, N=4 W=8.
   logic        rst1;
   logic [31:0] inData1;
   logic [3:0]  inValid1;
   logic [3:0]  inReady1;
   logic [1:0]  sel1;
   logic        selLoad1;
   logic        selErr1;
   logic [7:0]  outData1;
   logic [1:0]  outCh1;
   logic        outValid1;
   logic        outReady1;

`ifdef MUXN_REG_PARITY_EN
   logic        outPar0;
   logic        outParE;
   logic        outPar1;
`endif

   muxn_reg #(.N(4), .W(8), .MODE(0)) dut0 (
      .CLK(clk), .RST(rst0), .IN_DATA(inData0), .IN_VALID(inValid0), .IN_READY(inReady0),
      .SEL(sel0), .SEL_LOAD(selLoad0), .SEL_ERR(selErr0), .OUT_DATA(outData0),
      .OUT_CH(outCh0), .OUT_VALID(outValid0), .OUT_READY(outReady0)
`ifdef MUXN_REG_PARITY_EN
      , .OUT_PAR(outPar0)
`endif
   );

   muxn_reg #(.N(5), .W(8), .MODE(0)) dutE (
      .CLK(clk), .RST(rstE), .IN_DATA(inDataE), .IN_VALID(inValidE), .IN_READY(inReadyE),
      .SEL(selE), .SEL_LOAD(selLoadE), .SEL_ERR(selErrE), .OUT_DATA(outDataE),
      .OUT_CH(outChE), .OUT_VALID(outValidE), .OUT_READY(outReadyE)
`ifdef MUXN_REG_PARITY_EN
      , .OUT_PAR(outParE)
`endif
   );

   muxn_reg #(.N(4), .W(8), .MODE(1)) dut1 (
      .CLK(clk), .RST(rst1), .IN_DATA(inData1), .IN_VALID(inValid1), .IN_READY(inReady1),
      .SEL(sel1), .SEL_LOAD(selLoad1), .SEL_ERR(selErr1), .OUT_DATA(outData1),
      .OUT_CH(outCh1), .OUT_VALID(outValid1), .OUT_READY(outReady1)
`ifdef MUXN_REG_PARITY_EN
      , .OUT_PAR(outPar1)
`endif
   );

   initial clk = 1'b0;
   always #5 clk = ~clk;

   typedef struct {
      logic        selLoad;
      logic [1:0]  sel;
      logic [3:0]  inValid;
      logic [31:0] inData;
      logic        outReady;
      logic [3:0]  expInReady;
      logic        expValid;
      logic [7:0]  expData;
      logic [1:0]  expCh;
   } vec0_t;

   vec0_t vecs[12];

   task automatic checkOutput(input string name, input logic [63:0] act, input logic [63:0] exp);
      checks++;
      if (act !== exp) begin
         errors++;
         $display("[TB] FAIL %s: got 0x%0h, expected 0x%0h", name, act, exp);
      end
   endtask

   // Advance one clock and settle just after the edge.
   task automatic tick();
      @(posedge clk);
      #1;
   endtask

   task automatic applyStimulus(input vec0_t v);
      selLoad0  = v.selLoad;
      sel0      = v.sel;
      inValid0  = v.inValid;
      inData0   = v.inData;
      outReady0 = v.outReady;
   endtask

   localparam logic [31:0] D0 = 32'h44A5_2211;
   localparam logic [31:0] D1 = 32'h44A5_5A11;

   initial begin
      checks = 0;
      errors = 0;

      rst0 = 1'b1; inData0 = D0; inValid0 = '0; sel0 = '0; selLoad0 = 1'b0; outReady0 = 1'b0;
      rstE = 1'b1; inDataE = 40'h14_1312_1110; inValidE = '0; selE = '0; selLoadE = 1'b0; outReadyE = 1'b1;
      rst1 = 1'b1; inData1 = 32'hC3C2_C1C0; inValid1 = '0; sel1 = '0; selLoad1 = 1'b0; outReady1 = 1'b1;

      //                selLd sel   inValid  data ordy  expRdy   expV  expD   expCh
      vecs[0]  = '{1'b1, 2'd2, 4'b0000, D0, 1'b1, 4'b0001, 1'b0, 8'h00, 2'd0};
      vecs[1]  = '{1'b0, 2'd0, 4'b0100, D0, 1'b1, 4'b0100, 1'b1, 8'hA5, 2'd2};
      vecs[2]  = '{1'b0, 2'd0, 4'b0000, D0, 1'b1, 4'b0100, 1'b0, 8'hA5, 2'd2};
      vecs[3]  = '{1'b1, 2'd1, 4'b0110, D0, 1'b1, 4'b0100, 1'b1, 8'hA5, 2'd2};
      vecs[4]  = '{1'b0, 2'd0, 4'b0110, D0, 1'b1, 4'b0010, 1'b1, 8'h22, 2'd1};
      vecs[5]  = '{1'b0, 2'd0, 4'b0010, D1, 1'b0, 4'b0000, 1'b1, 8'h22, 2'd1};
      vecs[6]  = '{1'b0, 2'd0, 4'b0010, D1, 1'b0, 4'b0000, 1'b1, 8'h22, 2'd1};
      vecs[7]  = '{1'b0, 2'd0, 4'b0010, D1, 1'b1, 4'b0010, 1'b1, 8'h5A, 2'd1};
      vecs[8]  = '{1'b1, 2'd3, 4'b0000, D0, 1'b0, 4'b0000, 1'b1, 8'h5A, 2'd1};
      vecs[9]  = '{1'b0, 2'd0, 4'b1000, D0, 1'b0, 4'b0000, 1'b1, 8'h5A, 2'd1};
      vecs[10] = '{1'b0, 2'd0, 4'b1000, D0, 1'b1, 4'b1000, 1'b1, 8'h44, 2'd3};
      vecs[11] = '{1'b0, 2'd0, 4'b0000, D0, 1'b1, 4'b1000, 1'b0, 8'h44, 2'd3};

      tick();
      tick();
      checkOutput("rst0 outValid", 64'(outValid0), 64'd0);
      checkOutput("rst0 outData",  64'(outData0),  64'd0);
      checkOutput("rst0 outCh",    64'(outCh0),    64'd0);
      checkOutput("rst0 selErr",   64'(selErr0),   64'd0);
      checkOutput("rst0 inReady",  64'(inReady0),  64'd0);
      checkOutput("rst1 outValid", 64'(outValid1), 64'd0);
      checkOutput("rstE selErr",   64'(selErrE),   64'd0);
      rst0 = 1'b0; rstE = 1'b0; rst1 = 1'b0;

      // Fixed-select table: ready is checked before the edge, the register after.
      for (int i = 0; i < 12; i++) begin
         applyStimulus(vecs[i]);
         #1;
         checkOutput($sformatf("v%0d inReady", i), 64'(inReady0), 64'(vecs[i].expInReady));
         tick();
         checkOutput($sformatf("v%0d outValid", i), 64'(outValid0), 64'(vecs[i].expValid));
         checkOutput($sformatf("v%0d outData", i),  64'(outData0),  64'(vecs[i].expData));
         checkOutput($sformatf("v%0d outCh", i),    64'(outCh0),    64'(vecs[i].expCh));
         checkOutput($sformatf("v%0d selErr", i),   64'(selErr0),   64'd0);
      end

`ifdef MUXN_REG_PARITY_EN
      inData0 = 32'h07A5_2211; inValid0 = 4'b1000; outReady0 = 1'b1; selLoad0 = 1'b0;
      tick();
      checkOutput("par 07 data", 64'(outData0), 64'h07);
      checkOutput("par 07", 64'(outPar0), 64'd1);
      inData0 = 32'h03A5_2211;
      tick();
      checkOutput("par 03 data", 64'(outData0), 64'h03);
      checkOutput("par 03", 64'(outPar0), 64'd0);
`endif

      // Select-error sequence on the N=5 instance.
      selLoadE = 1'b1; selE = 3'd3; inValidE = '0;
      tick();
      checkOutput("E legal load err", 64'(selErrE), 64'd0);
      selE = 3'd5;
      tick();
      checkOutput("E sel5 err pulse", 64'(selErrE), 64'd1);
      selLoadE = 1'b0;
      tick();
      checkOutput("E err one cycle", 64'(selErrE), 64'd0);
      inValidE = 5'b01000;
      tick();
      checkOutput("E kept sel ch", 64'(outChE), 64'd3);
      checkOutput("E kept sel data", 64'(outDataE), 64'h13);
      inValidE = '0; selLoadE = 1'b1; selE = 3'd4;
      tick();
      checkOutput("E sel4 no err", 64'(selErrE), 64'd0);
      selLoadE = 1'b0; inValidE = 5'b10000;
      tick();
      checkOutput("E ch4 ch", 64'(outChE), 64'd4);
      checkOutput("E ch4 data", 64'(outDataE), 64'h14);
      inValidE = '0; selLoadE = 1'b1; selE = 3'd7;
      tick();
      checkOutput("E sel7 err", 64'(selErrE), 64'd1);
      selLoadE = 1'b0; inValidE = 5'b10000;
      tick();
      checkOutput("E after sel7 ch", 64'(outChE), 64'd4);

      // Round-robin rotation with all channels requesting; SEL_LOAD is ignored.
      inValid1 = 4'b1111; outReady1 = 1'b1; selLoad1 = 1'b1; sel1 = 2'd3;
      #1;
      checkOutput("rr first inReady", 64'(inReady1), 64'b0001);
      for (int k = 0; k < 5; k++) begin
         tick();
         checkOutput($sformatf("rr seq%0d ch", k), 64'(outCh1), 64'(k % 4));
         checkOutput($sformatf("rr seq%0d data", k), 64'(outData1), 64'(8'hC0 + (k % 4)));
         checkOutput($sformatf("rr seq%0d err", k), 64'(selErr1), 64'd0);
      end
      selLoad1 = 1'b0;

      // Pointer now 1: sparse requests wrap to channel 3, then channel 0.
      inValid1 = 4'b1001;
      #1;
      checkOutput("rr 1001 inReady", 64'(inReady1), 64'b1000);
      tick();
      checkOutput("rr 1001 first", 64'(outCh1), 64'd3);
      tick();
      checkOutput("rr 1001 second", 64'(outCh1), 64'd0);
      outReady1 = 1'b0;
      #1;
      checkOutput("rr full inReady", 64'(inReady1), 64'b0000);
      tick();
      checkOutput("rr hold valid", 64'(outValid1), 64'd1);
      checkOutput("rr hold ch", 64'(outCh1), 64'd0);
      rst1 = 1'b1; outReady1 = 1'b1;
      #1;
      checkOutput("rr inReady in rst", 64'(inReady1), 64'b0000);
      tick();
      checkOutput("rr rst valid", 64'(outValid1), 64'd0);
      checkOutput("rr rst data", 64'(outData1), 64'd0);
      rst1 = 1'b0; inValid1 = 4'b1111;
      #1;
      checkOutput("rr ptr0 inReady", 64'(inReady1), 64'b0001);
      tick();
      checkOutput("rr ptr0 grant", 64'(outCh1), 64'd0);
      checkOutput("rr ptr0 valid", 64'(outValid1), 64'd1);

      $display("Result: errors=%0d of %0d checks", errors, checks);
      $finish;
   end

endmodule
